mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Sequences one CPU load/store request onto the 32-bit memory port, using the MFA/MOC handshake.
- Sits between the control unit and RAM, and consumes the 2-bit data-size code (BYTE=00, HALF=01, WORD=10, DWORD=11).
- Splits a DWORD into two WORD beats, checks alignment and sign/zero-extends narrow loads.
- Aborts on misalignment or on a memory timeout.

Parameters:
TIMEOUT, 16, cycles MemMFA may stay high without MemMOC before Abort (must be ≥2).

Ports:
Clk  in  1  rising-edge clock
nReset  in  1  synchronous, active-low reset
Req  in  1  request; sampled only in IDLE
RW  in  1  1=read (load), 0=write (store)
DataSize  in  2  00 BYTE, 01 HALF, 10 WORD, 11 DWORD
Signed  in  1  sign-extend BYTE/HALF loads
Addr  in  32  byte address
WData  in  64  store data; [31:0] beat0, [63:32] beat1 (DWORD only)
Busy  out  1  high from accept until Done/Abort cycle inclusive
Done  out  1  one-cycle pulse on successful completion
Abort  out  1  one-cycle pulse on misalignment or timeout
RData  out  64  load result
MemMFA  out  1  memory function activate
MemRW  out  1  copy of latched RW
MemSize  out  2  00/01/10 only; DWORD issued as 10
MemAddr  out  32  beat address
MemWData  out  32  beat store data
MemRData  in  32  read data, right-justified
MemMOC  in  1  memory operation complete

Behaviour:
- Reset (nReset=0 at edge): state IDLE. All outputs 0: Busy, Done, Abort, RData, MemMFA, MemRW, MemSize, MemAddr, MemWData. Applies mid-transfer; MemMFA is low from the next cycle. A partial DWORD leaves RData unchanged.
- States: IDLE, CHECK, BEAT0, GAP, BEAT1, DONE, ABORT.
- IDLE: Req=1 latches RW, DataSize, Signed, Addr and WData, then goes to CHECK. Req in any other state is ignored.
- CHECK (1 cycle, Busy=1): misalignment goes to ABORT. Misaligned means HALF with Addr[0]≠0, or WORD/DWORD with Addr[1:0]≠0. Otherwise go to BEAT0.
- BEAT0: MemMFA=1, MemAddr=Addr, MemWData=WData[31:0]. MemSize=DataSize, except DWORD is issued as 10.
  - All Mem* outputs are held stable until MemMOC=1 is sampled.
  - On MOC: capture read data, clear the timeout counter. DWORD goes to GAP; otherwise go to DONE.
- GAP (1 cycle): MemMFA=0, so MFA is low at least one cycle between beats.
- BEAT1: MemAddr=Addr+4 (wraps mod 2^32), MemWData=WData[63:32], MemSize=10. On MOC go to DONE.
- Timeout: counter increments each BEAT cycle without MOC. If it reaches TIMEOUT while still in BEAT, go to ABORT; MemMFA is low from the next cycle. Equivalently, MOC must arrive within the first TIMEOUT cycles of MFA high.
- DONE: Done=1 for one cycle, MemMFA=0, return to IDLE.
- ABORT: Abort=1 for one cycle, MemMFA=0, RData unchanged, return to IDLE.
- Read result update: RData is updated only on reads, in the DONE cycle (staged captures), and is held otherwise.
  - BYTE: RData={56{Signed&b[7]}, b[7:0]}.
  - HALF: 48-bit extension of bits [15:0], sign-extended if Signed.
  - WORD: zero-extended to 64 bits.
  - DWORD: {beat1, beat0}.
- Writes never modify RData.
- MemMOC while MemMFA=0 is ignored.
- A new Req sampled in the DONE/ABORT cycle is ignored. The earliest next accept is the cycle after, i.e. one IDLE cycle.
- Latency: Req sampled at edge T means CHECK during T+1, MFA high T+2.
  - Zero-wait MOC at T+2 gives Done at T+3.
  - Zero-wait DWORD: beat0 T+2, GAP T+3, beat1 T+4, Done T+5.

Test Plan:
1. Signed BYTE load: Addr=0x103, Signed=1, MOC same cycle as MFA with MemRData=0x000000F0 → MemSize=00, MemAddr=0x103, Done at T+3, RData=0xFFFFFFFFFFFFFFF0. Repeat with Signed=0 → RData=0xF0.
2. DWORD store: Addr=0xFFFFFFFC, WData=0x11112222_33334444, zero-wait → beat0 MemAddr=0xFFFFFFFC, MemWData=0x33334444; MFA low at T+3; beat1 MemAddr=0x00000000, MemWData=0x11112222; Done at T+5; RData unchanged.
3. Misaligned WORD load: Addr=0x202 → MemMFA never rises; Abort pulse at T+2; Busy low at T+3; RData unchanged.
4. Timeout, TIMEOUT=16, MemMOC held 0 → MFA high exactly 16 cycles, then Abort pulse; MFA low thereafter. A late MOC after that is ignored.
5. Wait states plus mid-op reset: HALF load with 3-cycle MOC delay, MemRData=0x00008001, Signed=1 → Mem* outputs stable throughout, RData=0xFFFFFFFFFFFF8001. Then start a DWORD load and assert nReset during GAP → IDLE next cycle, all outputs 0, no Done.
6. Req held high continuously → exactly one transfer per Done. New accepts occur only in IDLE, and Req during BEAT0 causes no restart.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Sequences one CPU load/store onto a 32-bit MFA/MOC memory port.
// DWORDs are split into two WORD beats; narrow loads are extended into RData.
module mem_access_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        Req,
  input  logic        RW,
  input  logic [1:0]  DataSize,
  input  logic        Signed,
  input  logic [31:0] Addr,
  input  logic [63:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic        Abort,
  output logic [63:0] RData,
  output logic        MemMFA,
  output logic        MemRW,
  output logic [1:0]  MemSize,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemMOC
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0]  SZ_HALF  = 2'b01;
  localparam logic [1:0]  SZ_WORD  = 2'b10;
  localparam logic [1:0]  SZ_DWORD = 2'b11;

  typedef enum logic [2:0] {IDLE, CHECK, BEAT0, GAP, BEAT1, DONE, ABORT} state_t;

  state_t            state;
  logic              rw_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [31:0]       addr_q;
  logic [63:0]       wdata_q;
  logic [31:0]       beat0_q;
  logic [CNT_W-1:0]  tcnt;
  logic              misaligned_c;
  logic [63:0]       load_result_c;

  // Alignment rule applied to the latched request
  always_comb begin
    misaligned_c = 1'b0;
    case (size_q)
      SZ_HALF:            misaligned_c = addr_q[0];
      SZ_WORD, SZ_DWORD:  misaligned_c = |addr_q[1:0];
      default:            misaligned_c = 1'b0;
    endcase
  end

  // Final load value from the completing beat (and staged beat0 for DWORD)
  always_comb begin
    load_result_c = '0;
    case (size_q)
      2'b00:   load_result_c = {{56{signed_q & MemRData[7]}}, MemRData[7:0]};
      SZ_HALF: load_result_c = {{48{signed_q & MemRData[15]}}, MemRData[15:0]};
      SZ_WORD: load_result_c = {32'h0, MemRData};
      default: load_result_c = {MemRData, beat0_q};
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state    <= IDLE;
      rw_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      beat0_q  <= '0;
      tcnt     <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Abort    <= 1'b0;
      RData    <= '0;
      MemMFA   <= 1'b0;
      MemRW    <= 1'b0;
      MemSize  <= '0;
      MemAddr  <= '0;
      MemWData <= '0;
    end else begin
      Done  <= 1'b0;
      Abort <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            rw_q     <= RW;
            size_q   <= DataSize;
            signed_q <= Signed;
            addr_q   <= Addr;
            wdata_q  <= WData;
            MemRW    <= RW;
            Busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (misaligned_c) begin
            Abort <= 1'b1;
            state <= ABORT;
          end else begin
            MemMFA   <= 1'b1;
            MemAddr  <= addr_q;
            MemWData <= wdata_q[31:0];
            MemSize  <= (size_q == SZ_DWORD) ? SZ_WORD : size_q;
            tcnt     <= '0;
            state    <= BEAT0;
          end
        end
        BEAT0, BEAT1: begin
          // MOC on the last allowed cycle still completes the beat
          if (MemMOC) begin
            tcnt   <= '0;
            MemMFA <= 1'b0;
            if (state == BEAT0 && size_q == SZ_DWORD) begin
              beat0_q <= MemRData;
              state   <= GAP;
            end else begin
              Done  <= 1'b1;
              if (rw_q) RData <= load_result_c;
              state <= DONE;
            end
          end else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
            MemMFA <= 1'b0;
            Abort  <= 1'b1;
            state  <= ABORT;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        GAP: begin
          MemMFA   <= 1'b1;
          MemAddr  <= addr_q + 32'd4;
          MemWData <= wdata_q[63:32];
          MemSize  <= SZ_WORD;
          state    <= BEAT1;
        end
        DONE, ABORT: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed scenarios plus random transactions
// checked against a timeline model derived from the transfer rules.
module tb_mem_access_sequencer;

  localparam int unsigned TIMEOUT = 16;
  localparam int NEVER = 255;

  logic        Clk = 1'b0;
  logic        nReset, Req, RW, Signed, MemMOC;
  logic [1:0]  DataSize;
  logic [31:0] Addr, MemRData;
  logic [63:0] WData;
  logic        Busy, Done, Abort, MemMFA, MemRW;
  logic [1:0]  MemSize;
  logic [31:0] MemAddr, MemWData;
  logic [63:0] RData;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_rdata;

  // Observations from the last run_txn
  int          obs_done_k, obs_abort_k, obs_beats;
  int          obs_cyc [2];
  logic [31:0] obs_addr [2];
  logic [31:0] obs_wdata [2];
  logic [1:0]  obs_size [2];
  logic        obs_memrw, obs_busy_after;
  bit          obs_unstable, obs_busy_bad;
  logic [63:0] obs_rdata;

  // Responder state for the free-running memory model
  int   srv_cib;
  logic srv_prev;

  typedef struct {
    int          done_k;
    int          abort_k;
    int          beats;
    int          cyc0;
    int          cyc1;
    logic [1:0]  size0;
    logic [31:0] addr1;
    logic [63:0] rdata;
  } exp_t;

  mem_access_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .nReset(nReset), .Req(Req), .RW(RW), .DataSize(DataSize),
    .Signed(Signed), .Addr(Addr), .WData(WData), .Busy(Busy), .Done(Done),
    .Abort(Abort), .RData(RData), .MemMFA(MemMFA), .MemRW(MemRW),
    .MemSize(MemSize), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemMOC(MemMOC)
  );

  always #5 Clk = ~Clk;

  // Timeline model: cycle k counts from the accept edge (k=1 is CHECK)
  function automatic exp_t model_txn(input logic rw, input logic [1:0] sz, input logic sg,
                                     input logic [31:0] a, input int d0, input int d1,
                                     input logic [31:0] r0, input logic [31:0] r1,
                                     input logic [63:0] prev);
    exp_t e;
    logic [63:0] ext;
    e.done_k = -1; e.abort_k = -1; e.beats = 0; e.cyc0 = 0; e.cyc1 = 0;
    e.size0 = (sz == 2'd3) ? 2'd2 : sz;
    e.addr1 = a + 32'd4;
    e.rdata = prev;
    if ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0)) begin
      e.abort_k = 2;
      return e;
    end
    e.beats = 1;
    if (d0 >= int'(TIMEOUT)) begin
      e.cyc0 = int'(TIMEOUT); e.abort_k = 2 + int'(TIMEOUT);
      return e;
    end
    e.cyc0 = d0 + 1;
    if (sz != 2'd3) begin
      e.done_k = 3 + d0;
      case (sz)
        2'd0:    ext = 64'(r0 & 32'hFF)   | ((sg && r0[7])  ? ~64'hFF   : 64'h0);
        2'd1:    ext = 64'(r0 & 32'hFFFF) | ((sg && r0[15]) ? ~64'hFFFF : 64'h0);
        default: ext = 64'(r0);
      endcase
      if (rw) e.rdata = ext;
      return e;
    end
    e.beats = 2;
    if (d1 >= int'(TIMEOUT)) begin
      e.cyc1 = int'(TIMEOUT); e.abort_k = 4 + d0 + int'(TIMEOUT);
      return e;
    end
    e.cyc1 = d1 + 1;
    e.done_k = 5 + d0 + d1;
    if (rw) e.rdata = {r1, r0};
    return e;
  endfunction

  // Issues one request and plays memory with the given per-beat MOC delays
  task automatic run_txn(input logic rw, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [63:0] wd,
                         input int d0, input int d1,
                         input logic [31:0] r0, input logic [31:0] r1);
    int beat, bi, cib;
    logic prev_mfa;
    bit fin;
    obs_done_k = -1; obs_abort_k = -1; obs_unstable = 0; obs_busy_bad = 0;
    obs_cyc[0] = 0; obs_cyc[1] = 0; obs_memrw = 1'b0;
    @(negedge Clk);
    Req = 1'b1; RW = rw; DataSize = sz; Signed = sg; Addr = a; WData = wd;
    MemMOC = 1'b0;
    beat = -1; cib = 0; prev_mfa = 1'b0; fin = 0;
    for (int k = 1; k <= 60 && !fin; k++) begin
      @(negedge Clk);
      if (k == 1) begin
        Req = 1'b0; RW = ~rw; DataSize = 2'($urandom_range(0, 3)); Signed = ~sg;
        Addr = $urandom; WData = {$urandom, $urandom};
        obs_memrw = MemRW;
      end
      if (MemMFA) begin
        if (!prev_mfa) begin
          beat++;
          cib = 0;
          bi = (beat > 1) ? 1 : beat;
          obs_addr[bi] = MemAddr; obs_wdata[bi] = MemWData; obs_size[bi] = MemSize;
        end else begin
          bi = (beat > 1) ? 1 : beat;
          if ({MemAddr, MemWData, MemSize, MemRW} !==
              {obs_addr[bi], obs_wdata[bi], obs_size[bi], obs_memrw}) obs_unstable = 1;
        end
        obs_cyc[bi]++;
        MemMOC = (cib == ((bi == 0) ? d0 : d1));
        MemRData = MemMOC ? ((bi == 0) ? r0 : r1) : $urandom;
        cib++;
      end else begin
        MemMOC = 1'($urandom);
        MemRData = $urandom;
      end
      prev_mfa = MemMFA;
      if (!Busy) obs_busy_bad = 1;
      if (Done && obs_done_k < 0) obs_done_k = k;
      if (Abort && obs_abort_k < 0) obs_abort_k = k;
      if (Done || Abort) fin = 1;
    end
    obs_beats = beat + 1;
    @(negedge Clk);
    MemMOC = 1'b0;
    obs_busy_after = Busy;
    obs_rdata = RData;
  endtask

  // Zero-intelligence memory: answers each MFA burst after d cycles
  task automatic serve_mem(input int d);
    if (MemMFA) begin
      if (!srv_prev) srv_cib = 0;
      MemMOC = (srv_cib == d);
      MemRData = $urandom;
      srv_cib++;
    end else begin
      MemMOC = 1'b0;
    end
    srv_prev = MemMFA;
  endtask

  task automatic test_reset;
    nReset = 1'b0; Req = 1'b0; RW = 1'b0; DataSize = '0; Signed = 1'b0;
    Addr = '0; WData = '0; MemRData = '0; MemMOC = 1'b0;
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    vectors++;
    if ({Busy, Done, Abort, MemMFA, MemRW, MemSize, MemAddr, MemWData, RData} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got busy=%b done=%b abort=%b mfa=%b rw=%b size=%h addr=%h wdata=%h rdata=%h required all zero",
               Busy, Done, Abort, MemMFA, MemRW, MemSize, MemAddr, MemWData, RData);
    end
    exp_rdata = '0;
  endtask

  task automatic test_signed_byte;
    for (int s = 1; s >= 0; s--) begin
      exp_t e;
      e = model_txn(1'b1, 2'd0, 1'(s), 32'h103, 0, 0, 32'hF0, 32'h0, exp_rdata);
      run_txn(1'b1, 2'd0, 1'(s), 32'h103, 64'h0, 0, 0, 32'h000000F0, 32'h0);
      vectors++;
      if (obs_size[0] !== 2'd0 || obs_addr[0] !== 32'h103) begin
        miscompares++;
        $display("FAIL byte_beat s=%0d got size=%h addr=%h required 0/00000103", s, obs_size[0], obs_addr[0]);
      end
      vectors++;
      if (obs_done_k !== 3) begin
        miscompares++;
        $display("FAIL byte_done_k s=%0d got %0d required 3", s, obs_done_k);
      end
      vectors++;
      if (obs_rdata !== e.rdata || e.rdata !== (s ? 64'hFFFFFFFFFFFFFFF0 : 64'hF0)) begin
        miscompares++;
        $display("FAIL byte_rdata s=%0d got %h required %h", s, obs_rdata, e.rdata);
      end
      exp_rdata = e.rdata;
    end
  endtask

  task automatic test_dword_store;
    run_txn(1'b0, 2'd3, 1'b0, 32'hFFFFFFFC, 64'h11112222_33334444, 0, 0, $urandom, $urandom);
    vectors++;
    if (obs_beats !== 2 || obs_cyc[0] !== 1 || obs_cyc[1] !== 1) begin
      miscompares++;
      $display("FAIL dword_beats got beats=%0d cyc=%0d/%0d required 2 beats 1/1", obs_beats, obs_cyc[0], obs_cyc[1]);
    end
    vectors++;
    if (obs_addr[0] !== 32'hFFFFFFFC || obs_wdata[0] !== 32'h33334444 || obs_size[0] !== 2'd2) begin
      miscompares++;
      $display("FAIL dword_beat0 got addr=%h wdata=%h size=%h required FFFFFFFC/33334444/2", obs_addr[0], obs_wdata[0], obs_size[0]);
    end
    vectors++;
    if (obs_addr[1] !== 32'h0 || obs_wdata[1] !== 32'h11112222 || obs_size[1] !== 2'd2) begin
      miscompares++;
      $display("FAIL dword_beat1 got addr=%h wdata=%h size=%h required 00000000/11112222/2", obs_addr[1], obs_wdata[1], obs_size[1]);
    end
    vectors++;
    if (obs_done_k !== 5 || obs_rdata !== exp_rdata) begin
      miscompares++;
      $display("FAIL dword_done got k=%0d rdata=%h required 5/%h", obs_done_k, obs_rdata, exp_rdata);
    end
  endtask

  task automatic test_misaligned;
    run_txn(1'b1, 2'd2, 1'b0, 32'h202, 64'h0, 0, 0, 32'h12345678, 32'h0);
    vectors++;
    if (obs_beats !== 0 || obs_abort_k !== 2 || obs_done_k !== -1) begin
      miscompares++;
      $display("FAIL misalign got beats=%0d abort_k=%0d done_k=%0d required 0/2/-1", obs_beats, obs_abort_k, obs_done_k);
    end
    vectors++;
    if (obs_busy_after !== 1'b0 || obs_rdata !== exp_rdata) begin
      miscompares++;
      $display("FAIL misalign_after got busy=%b rdata=%h required 0/%h", obs_busy_after, obs_rdata, exp_rdata);
    end
  endtask

  task automatic test_timeout;
    run_txn(1'b1, 2'd2, 1'b0, 32'h300, 64'h0, NEVER, 0, 32'h0, 32'h0);
    vectors++;
    if (obs_cyc[0] !== int'(TIMEOUT) || obs_abort_k !== 2 + int'(TIMEOUT)) begin
      miscompares++;
      $display("FAIL timeout got mfa_cycles=%0d abort_k=%0d required %0d/%0d", obs_cyc[0], obs_abort_k, TIMEOUT, 2 + TIMEOUT);
    end
    MemMOC = 1'b1;
    MemRData = 32'hCAFEF00D;
    repeat (3) begin
      @(negedge Clk);
      vectors++;
      if (MemMFA !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0 || RData !== exp_rdata) begin
        miscompares++;
        $display("FAIL late_moc got mfa=%b done=%b busy=%b rdata=%h required 0/0/0/%h", MemMFA, Done, Busy, RData, exp_rdata);
      end
    end
    MemMOC = 1'b0;
  endtask

  task automatic test_wait_reset;
    exp_t e;
    e = model_txn(1'b1, 2'd1, 1'b1, 32'h500, 3, 0, 32'h00008001, 32'h0, exp_rdata);
    run_txn(1'b1, 2'd1, 1'b1, 32'h500, 64'h0, 3, 0, 32'h00008001, 32'h0);
    vectors++;
    if (obs_unstable || obs_cyc[0] !== 4 || obs_done_k !== 6) begin
      miscompares++;
      $display("FAIL half_wait got unstable=%0d cyc=%0d done_k=%0d required 0/4/6", obs_unstable, obs_cyc[0], obs_done_k);
    end
    vectors++;
    if (obs_rdata !== e.rdata || e.rdata !== 64'hFFFFFFFFFFFF8001) begin
      miscompares++;
      $display("FAIL half_rdata got %h required FFFFFFFFFFFF8001", obs_rdata);
    end
    exp_rdata = e.rdata;
    @(negedge Clk);
    Req = 1'b1; RW = 1'b1; DataSize = 2'd3; Signed = 1'b0; Addr = 32'h400;
    @(negedge Clk);
    Req = 1'b0;
    @(negedge Clk);
    vectors++;
    if (MemMFA !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_beat0 mfa got %b required 1", MemMFA);
    end
    MemMOC = 1'b1; MemRData = 32'hDEADBEEF;
    @(negedge Clk);
    MemMOC = 1'b0;
    vectors++;
    if (MemMFA !== 1'b0 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_gap got mfa=%b busy=%b required 0/1", MemMFA, Busy);
    end
    nReset = 1'b0;
    @(negedge Clk);
    nReset = 1'b1;
    vectors++;
    if ({Busy, Done, Abort, MemMFA, MemRW, MemSize, MemAddr, MemWData, RData} !== '0) begin
      miscompares++;
      $display("FAIL midop_reset got busy=%b done=%b mfa=%b addr=%h rdata=%h required all zero",
               Busy, Done, MemMFA, MemAddr, RData);
    end
    exp_rdata = '0;
    repeat (5) begin
      @(negedge Clk);
      MemMOC = 1'($urandom);
      vectors++;
      if (Done !== 1'b0 || MemMFA !== 1'b0 || Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle got done=%b mfa=%b busy=%b required 0/0/0", Done, MemMFA, Busy);
      end
    end
    MemMOC = 1'b0;
  endtask

  task automatic test_req_held;
    int d, p, ph;
    bit drained;
    d = 2;
    p = 4 + d;
    srv_cib = 0; srv_prev = 1'b0;
    @(negedge Clk);
    Req = 1'b1; RW = 1'b0; DataSize = 2'd2; Signed = 1'b0; Addr = 32'h600; WData = {$urandom, $urandom};
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      ph = k % p;
      vectors++;
      if (Done !== 1'(ph == 3 + d) || Busy !== 1'(ph != 0)) begin
        miscompares++;
        $display("FAIL req_held k=%0d got done=%b busy=%b required %b/%b", k, Done, Busy, ph == 3 + d, ph != 0);
      end
      serve_mem(d);
    end
    Req = 1'b0;
    drained = 0;
    for (int k = 0; k < 30 && !drained; k++) begin
      @(negedge Clk);
      if (!Busy) drained = 1;
      else serve_mem(d);
    end
    MemMOC = 1'b0;
    vectors++;
    if (!drained || RData !== exp_rdata) begin
      miscompares++;
      $display("FAIL req_held_drain got drained=%0d rdata=%h required 1/%h", drained, RData, exp_rdata);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      exp_t e;
      logic rw, sg;
      logic [1:0] sz;
      logic [31:0] a, r0, r1;
      logic [63:0] wd;
      int d0, d1;
      rw = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC;
      wd = {$urandom, $urandom}; r0 = $urandom; r1 = $urandom;
      d0 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
      d1 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
      e = model_txn(rw, sz, sg, a, d0, d1, r0, r1, exp_rdata);
      run_txn(rw, sz, sg, a, wd, d0, d1, r0, r1);
      vectors++;
      if (obs_done_k !== e.done_k || obs_abort_k !== e.abort_k || obs_beats !== e.beats) begin
        miscompares++;
        $display("FAIL rnd%0d outcome got done_k=%0d abort_k=%0d beats=%0d required %0d/%0d/%0d",
                 n, obs_done_k, obs_abort_k, obs_beats, e.done_k, e.abort_k, e.beats);
      end
      vectors++;
      if (obs_cyc[0] !== e.cyc0 || obs_cyc[1] !== e.cyc1) begin
        miscompares++;
        $display("FAIL rnd%0d mfa_cycles got %0d/%0d required %0d/%0d", n, obs_cyc[0], obs_cyc[1], e.cyc0, e.cyc1);
      end
      if (e.beats >= 1) begin
        vectors++;
        if (obs_addr[0] !== a || obs_wdata[0] !== wd[31:0] || obs_size[0] !== e.size0) begin
          miscompares++;
          $display("FAIL rnd%0d beat0 got addr=%h wdata=%h size=%h required %h/%h/%h",
                   n, obs_addr[0], obs_wdata[0], obs_size[0], a, wd[31:0], e.size0);
        end
      end
      if (e.beats == 2) begin
        vectors++;
        if (obs_addr[1] !== e.addr1 || obs_wdata[1] !== wd[63:32] || obs_size[1] !== 2'd2) begin
          miscompares++;
          $display("FAIL rnd%0d beat1 got addr=%h wdata=%h size=%h required %h/%h/2",
                   n, obs_addr[1], obs_wdata[1], obs_size[1], e.addr1, wd[63:32]);
        end
      end
      vectors++;
      if (obs_rdata !== e.rdata) begin
        miscompares++;
        $display("FAIL rnd%0d rdata got %h required %h", n, obs_rdata, e.rdata);
      end
      vectors++;
      if (obs_memrw !== rw || obs_unstable || obs_busy_bad || obs_busy_after !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd%0d handshake got memrw=%b unstable=%0d busy_gap=%0d busy_after=%b required %b/0/0/0",
                 n, obs_memrw, obs_unstable, obs_busy_bad, obs_busy_after, rw);
      end
      exp_rdata = e.rdata;
    end
  endtask

  initial begin
    test_reset();
    test_signed_byte();
    test_dword_store();
    test_misaligned();
    test_timeout();
    test_wait_reset();
    test_req_held();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
